// File: rtl/vga_game_pkg.sv
// Shared game-state encoding, timing defaults and the frame-stable scene word set.
// Pure declarations; no latency or flow control of its own.
package vga_game_pkg;

  localparam logic [1:0] MODE_SPLASH = 2'd0;
  localparam logic [1:0] MODE_PLAY   = 2'd1;
  localparam logic [1:0] MODE_CRASH  = 2'd2;
  localparam logic [1:0] MODE_OVER   = 2'd3;

  localparam int CRASH_FRAMES_DEF = 60;
  localparam int FLASH_PERIOD_DEF = 4;

  typedef struct packed {
    logic [31:0] pipe1;
    logic [31:0] pipe2;
    logic [31:0] pipe3;
    logic [31:0] pipe4;
    logic [31:0] bird;
    logic [31:0] score;
  } scene_t;

endpackage

// File: rtl/button_edge_detect.sv
// Two-flop synchronizer for a raw button plus rising-edge detect on the synchronized level.
// Edge appears 2 clocks after the button rises and lasts one cycle; no backpressure.
module button_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  // [0],[1] synchronize; [2] holds the previous synchronized level
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], btn};
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/display_frame_sequencer.sv
// Game-state sequencer and frame-stable display shadows, advancing only on screen_end.
// State/shadow updates visible 1 cycle after screen_end; jump_pulse 1 cycle after an edge; no backpressure.
module display_frame_sequencer
  import vga_game_pkg::*;
#(
  parameter int CRASH_FRAMES = CRASH_FRAMES_DEF,
  parameter int FLASH_PERIOD = FLASH_PERIOD_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        screen_end,
  input  logic        jump,
  input  logic        collision,
  input  logic [31:0] pipe1_in,
  input  logic [31:0] pipe2_in,
  input  logic [31:0] pipe3_in,
  input  logic [31:0] pipe4_in,
  input  logic [31:0] bird_in,
  input  logic [31:0] score_in,
  input  logic [31:0] high_score_in,
  output logic [31:0] pipe1,
  output logic [31:0] pipe2,
  output logic [31:0] pipe3,
  output logic [31:0] pipe4,
  output logic [31:0] bird_top_left,
  output logic [31:0] current_score,
  output logic [31:0] high_score,
  output logic [1:0]  mode,
  output logic        jump_pulse,
  output logic        flash_on,
  output logic [15:0] frame_count
);

  localparam logic [7:0] CRASH_LOAD = 8'(CRASH_FRAMES);
  localparam logic [3:0] FLASH_LAST = 4'(FLASH_PERIOD - 1);

  logic       jump_rise;
  logic       jump_pending;
  logic       go;
  logic [7:0] crash_timer;
  logic [3:0] flash_cnt;
  scene_t     scene_q;

  button_edge_detect u_jump_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (jump),
    .rise  (jump_rise)
  );

  // An edge landing in the screen_end cycle counts as if it were already pending
  assign go = jump_pending | jump_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode        <= MODE_SPLASH;
      crash_timer <= '0;
      flash_on    <= 1'b0;
      flash_cnt   <= '0;
    end else if (screen_end) begin
      case (mode)
        MODE_SPLASH: if (go) mode <= MODE_PLAY;
        MODE_PLAY: begin
          if (collision) begin
            mode        <= MODE_CRASH;
            crash_timer <= CRASH_LOAD;
            flash_on    <= 1'b1;
            flash_cnt   <= '0;
          end
        end
        MODE_CRASH: begin
          if (crash_timer == 8'd1) begin
            mode        <= MODE_OVER;
            crash_timer <= '0;
            flash_on    <= 1'b0;
            flash_cnt   <= '0;
          end else begin
            crash_timer <= crash_timer - 8'd1;
            if (flash_cnt == FLASH_LAST) begin
              flash_on  <= ~flash_on;
              flash_cnt <= '0;
            end else begin
              flash_cnt <= flash_cnt + 4'd1;
            end
          end
        end
        MODE_OVER:  if (go) mode <= MODE_SPLASH;
        default:    mode <= MODE_SPLASH;
      endcase
    end
  end

  // Presses during the crash animation must not carry over into OVER
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               jump_pending <= 1'b0;
    else if (screen_end || mode == MODE_CRASH) jump_pending <= 1'b0;
    else if (jump_rise)                        jump_pending <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) jump_pulse <= 1'b0;
    else        jump_pulse <= jump_rise && (mode == MODE_PLAY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scene_q     <= '0;
      high_score  <= '0;
      frame_count <= '0;
    end else if (screen_end) begin
      high_score  <= high_score_in;
      frame_count <= frame_count + 16'd1;
      if (mode == MODE_PLAY) begin
        scene_q <= '{pipe1: pipe1_in, pipe2: pipe2_in, pipe3: pipe3_in,
                     pipe4: pipe4_in, bird: bird_in, score: score_in};
      end else if (mode == MODE_OVER && go) begin
        scene_q <= '0;
      end
    end
  end

  assign pipe1         = scene_q.pipe1;
  assign pipe2         = scene_q.pipe2;
  assign pipe3         = scene_q.pipe3;
  assign pipe4         = scene_q.pipe4;
  assign bird_top_left = scene_q.bird;
  assign current_score = scene_q.score;

endmodule

// File: tb/tb_display_frame_sequencer.sv
// Directed plus randomized bench for display_frame_sequencer against a frame-level game model.
// Inputs change 1 time unit after the rising edge; outputs are compared at the same point.
module tb_display_frame_sequencer;
  import vga_game_pkg::*;

  localparam int CF = 60;
  localparam int FP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        screen_end = 1'b0;
  logic        jump = 1'b0;
  logic        collision = 1'b0;
  logic [31:0] pin [7];
  logic [31:0] pipe1, pipe2, pipe3, pipe4, bird_top_left, current_score, high_score;
  logic [1:0]  mode;
  logic        jump_pulse, flash_on;
  logic [15:0] frame_count;

  display_frame_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .screen_end    (screen_end),
    .jump          (jump),
    .collision     (collision),
    .pipe1_in      (pin[0]),
    .pipe2_in      (pin[1]),
    .pipe3_in      (pin[2]),
    .pipe4_in      (pin[3]),
    .bird_in       (pin[4]),
    .score_in      (pin[5]),
    .high_score_in (pin[6]),
    .pipe1         (pipe1),
    .pipe2         (pipe2),
    .pipe3         (pipe3),
    .pipe4         (pipe4),
    .bird_top_left (bird_top_left),
    .current_score (current_score),
    .high_score    (high_score),
    .mode          (mode),
    .jump_pulse    (jump_pulse),
    .flash_on      (flash_on),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  // Game model: 0 splash, 1 play, 2 crash, 3 over
  int          m_mode;
  bit          m_pending;
  int          m_left;
  int          m_elapsed;
  int          m_frames;
  logic [31:0] m_sh [7];
  bit          m_pulse;
  bit          h0, h1, h2;   // last three clock samples of the button, newest first
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pending = 0; m_left = 0; m_elapsed = 0; m_frames = 0; m_pulse = 0;
    h0 = 0; h1 = 0; h2 = 0;
    for (int i = 0; i < 7; i++) m_sh[i] = '0;
  endtask

  task automatic check_all();
    bit exp_flash;
    exp_flash = (m_mode == 2) && (((m_elapsed / FP) % 2) == 0);
    chk("mode", 32'(mode), 32'(m_mode));
    chk("jump_pulse", 32'(jump_pulse), 32'(m_pulse));
    chk("flash_on", 32'(flash_on), 32'(exp_flash));
    chk("frame_count", 32'(frame_count), 32'(m_frames));
    chk("pipe1", pipe1, m_sh[0]);
    chk("pipe2", pipe2, m_sh[1]);
    chk("pipe3", pipe3, m_sh[2]);
    chk("pipe4", pipe4, m_sh[3]);
    chk("bird", bird_top_left, m_sh[4]);
    chk("score", current_score, m_sh[5]);
    chk("high_score", high_score, m_sh[6]);
  endtask

  // Advance the model by one clock using the inputs as they stand, then the DUT.
  task automatic tick(input bit do_chk);
    bit rise;
    rise = h1 && !h2;
    m_pulse = rise && (m_mode == 1);
    if (screen_end) begin
      m_frames = (m_frames + 1) % 65536;
      m_sh[6] = pin[6];
      case (m_mode)
        0: if (m_pending || rise) m_mode = 1;
        1: begin
          for (int i = 0; i < 6; i++) m_sh[i] = pin[i];
          if (collision) begin m_mode = 2; m_left = CF; m_elapsed = 0; end
        end
        2: if (m_left == 1) m_mode = 3; else begin m_left--; m_elapsed++; end
        default: if (m_pending || rise) begin
          m_mode = 0;
          for (int i = 0; i < 6; i++) m_sh[i] = '0;
        end
      endcase
      m_pending = 0;
    end else if (rise && m_mode != 2) begin
      m_pending = 1;
    end
    h2 = h1; h1 = h0; h0 = jump;
    @(posedge clk); #1;
    if (do_chk) check_all();
  endtask

  task automatic frame(input int len);
    for (int c = 0; c < len; c++) begin
      screen_end = (c == len - 1);
      tick(1);
    end
    screen_end = 1'b0;
  endtask

  task automatic press_and_end_frame();
    jump = 1'b1;
    tick(1); tick(1);
    screen_end = 1'b1;
    tick(1);
    screen_end = 1'b0;
    jump = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 7; i++) pin[i] = '0;
    model_reset();
    #12;
    check_all();
    @(posedge clk); #1;
    reset = 1'b1;

    // Splash to play on a press landing in the screen_end cycle; no pulse for it
    press_and_end_frame();
    chk("spl2play_mode", 32'(mode), 32'(MODE_PLAY));
    chk("spl2play_nopulse", 32'(jump_pulse), 32'd0);
    tick(1); tick(1); tick(1);

    // Shadow stays frozen mid-frame, loads at screen_end
    pin[0] = 32'h00A0_0100;
    tick(1); tick(1); tick(1);
    chk("pipe1_hold", pipe1, 32'd0);
    screen_end = 1'b1; tick(1); screen_end = 1'b0;
    chk("pipe1_load", pipe1, 32'h00A0_0100);

    // Jump pulse in play, one cycle wide
    jump = 1'b1;
    tick(1); tick(1); tick(1);
    chk("play_pulse", 32'(jump_pulse), 32'd1);
    tick(1);
    chk("play_pulse_end", 32'(jump_pulse), 32'd0);
    jump = 1'b0;
    tick(1); tick(1); tick(1);

    // Collision beats a simultaneous jump
    for (int i = 0; i < 7; i++) pin[i] = $urandom;
    jump = 1'b1;
    tick(1); tick(1);
    collision = 1'b1; screen_end = 1'b1;
    tick(1);
    collision = 1'b0; screen_end = 1'b0; jump = 1'b0;
    chk("crash_mode", 32'(mode), 32'(MODE_CRASH));
    chk("crash_flash", 32'(flash_on), 32'd1);
    for (int f = 1; f < CF; f++) begin
      if (f == 20) jump = 1'b1;
      if (f == 22) jump = 1'b0;
      for (int i = 0; i < 6; i++) pin[i] = $urandom;
      frame(3);
    end
    chk("crash_last", 32'(mode), 32'(MODE_CRASH));
    frame(3);
    chk("crash2over", 32'(mode), 32'(MODE_OVER));
    frame(3);
    chk("over_no_stale_jump", 32'(mode), 32'(MODE_OVER));

    // Over to splash clears the scene, high score keeps tracking
    for (int i = 0; i < 7; i++) pin[i] = $urandom;
    press_and_end_frame();
    chk("over2splash", 32'(mode), 32'(MODE_SPLASH));
    chk("splash_pipe1", pipe1, 32'd0);
    chk("splash_score", current_score, 32'd0);
    chk("splash_high", high_score, pin[6]);
    tick(1); tick(1);

    // Frame counter wrap
    screen_end = 1'b1;
    for (int n = m_frames; n < 65535; n++) tick(0);
    screen_end = 1'b0;
    tick(1);
    chk("fc_max", 32'(frame_count), 32'h0000_FFFF);
    screen_end = 1'b1; tick(1); screen_end = 1'b0;
    chk("fc_wrap", 32'(frame_count), 32'd0);

    // Random play
    for (int f = 0; f < 300; f++) begin
      int len;
      len = $urandom_range(2, 8);
      collision = ($urandom_range(0, 9) == 0);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 3) == 0) jump = ~jump;
        if ($urandom_range(0, 2) == 0) pin[$urandom_range(0, 6)] = $urandom;
        screen_end = (c == len - 1);
        tick(1);
      end
      screen_end = 1'b0;
    end
    collision = 1'b0; jump = 1'b0;
    tick(1); tick(1); tick(1);

    // Asynchronous reset in the middle of a crash
    reset = 1'b0;
    tick(0); tick(0);
    reset = 1'b1;
    model_reset();
    tick(1);
    press_and_end_frame();
    for (int i = 0; i < 7; i++) pin[i] = $urandom | 32'h1;
    tick(1); tick(1);
    collision = 1'b1; screen_end = 1'b1;
    tick(1);
    collision = 1'b0; screen_end = 1'b0;
    for (int f = 0; f < 30; f++) frame(2);
    chk("mid_crash_mode", 32'(mode), 32'(MODE_CRASH));
    chk("mid_crash_left", 32'(m_left), 32'd30);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_mode", 32'(mode), 32'(MODE_SPLASH));
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    tick(1); tick(1); tick(1);
    chk("post_rst_idle", 32'(mode), 32'(MODE_SPLASH));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_frame_sequencer.md
DISPLAY_FRAME_SEQUENCER -- requirements
Module: display_frame_sequencer

Interface
REQ-001 SHALL have parameter CRASH_FRAMES, default 60, frames spent in CRASH before OVER (range 1..255).
REQ-002 SHALL have parameter FLASH_PERIOD, default 4, frames per flash_on half-period (power of two, 1..16).
REQ-003 SHALL have port clk  in  1  100 MHz system clock, sole clock.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port screen_end  in  1  one-cycle pulse in clk domain marking the inter-frame gap.
REQ-006 SHALL have port jump  in  1  raw asynchronous button level.
REQ-007 SHALL have port collision  in  1  level from game logic, 1 while the bird overlaps a pipe or the screen edge.
REQ-008 SHALL have ports pipe1_in, pipe2_in, pipe3_in, pipe4_in, bird_in, score_in, high_score_in  in  32 each  live game register words.
REQ-009 SHALL have ports pipe1, pipe2, pipe3, pipe4, bird_top_left, current_score, high_score  out  32 each  frame-stable shadow copies for the display.
REQ-010 SHALL have port mode  out  2  game state (encoding per REQ-013).
REQ-011 SHALL have port jump_pulse  out  1  one-cycle pulse per accepted jump, to the processor.
REQ-012 SHALL have ports flash_on  out  1 and frame_count  out  16  crash-flash enable and free-running frame counter.

Function
REQ-013 SHALL implement states SPLASH=0, PLAY=1, CRASH=2, OVER=3; state changes occur only in a screen_end cycle, visible on mode the following cycle.
REQ-014 SHALL synchronize jump through two flops and detect rising edges; each edge sets jump_pending.
REQ-015 SHALL clear jump_pending in the screen_end cycle that consumes it; an edge coinciding with that screen_end SHALL be consumed in that same cycle.
REQ-016 SHALL transition SPLASH->PLAY at screen_end when jump_pending or an edge is present.
REQ-017 SHALL transition PLAY->CRASH at screen_end when collision=1, loading crash_timer with CRASH_FRAMES; collision SHALL win over a simultaneous jump.
REQ-018 SHALL decrement crash_timer at each screen_end in CRASH and go to OVER at the screen_end where it reads 1.
REQ-019 SHALL transition OVER->SPLASH at screen_end when jump_pending or an edge is present; jump edges during CRASH SHALL be discarded (jump_pending held clear).
REQ-020 SHALL emit jump_pulse one cycle after each synchronized rising edge while mode=PLAY, independent of screen_end; no pulse in any other state.
REQ-021 SHALL, in a screen_end cycle with mode=PLAY, load all seven shadow outputs from the corresponding inputs, visible the next cycle.
REQ-022 SHALL hold pipe/bird/current_score shadows frozen in CRASH and OVER, and load them with zero at the SPLASH entry.
REQ-023 SHALL load high_score from high_score_in at every screen_end regardless of state.
REQ-024 SHALL increment frame_count at every screen_end, wrapping 0xFFFF->0x0000.
REQ-025 SHALL drive flash_on = 0 outside CRASH; in CRASH it SHALL toggle every FLASH_PERIOD frames, starting at 1 on CRASH entry.

Reset
REQ-026 SHALL, on reset=0, immediately force mode=SPLASH, all shadows=0, frame_count=0, crash_timer=0, jump_pending=0, sync flops=0, jump_pulse=0, flash_on=0.
REQ-027 SHALL treat reset asserted mid-frame or mid-CRASH identically; first post-release transition requires a screen_end.

Structure
REQ-028 SHALL take state encoding, CRASH_FRAMES and FLASH_PERIOD defaults from shared package vga_game_pkg.
REQ-029 SHALL place jump synchronization and edge detection in sub-module button_edge_detect.

Verification
REQ-030 Reset, jump edge, then screen_end -> mode 0->1 next cycle; jump_pulse not asserted for that edge.
REQ-031 PLAY, pipe1_in=0x00A0_0100 changed mid-frame -> pipe1 unchanged until screen_end, equals 0x00A0_0100 one cycle after.
REQ-032 PLAY, collision=1 and jump edge on same screen_end -> mode=2, flash_on=1, no PLAY continuation; after 60 further screen_ends mode=3.
REQ-033 OVER, jump edge coinciding with screen_end -> mode=0 next cycle, pipe1..current_score=0, high_score tracks input.
REQ-034 frame_count preloaded to 0xFFFF via 65535 screen_ends -> next screen_end gives 0x0000.
REQ-035 reset pulsed low during CRASH with crash_timer=30 -> mode=0 and all outputs 0 asynchronously, before next clk edge.
